// File: rtl/jkff_bank_scheduler_pkg.sv
// Shared types and constants for the JK bank scheduler: FSM states, command
// encodings and an index range helper.
package jkff_bank_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_TGL  = 2'b11;

    function automatic logic idx_oob(input int unsigned idx, input int unsigned w);
        return idx >= w;
    endfunction

endpackage

// File: rtl/jkff_bank_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// above ptr_i, wrapping around. Kept generic so other schedulers can reuse it.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_i) + off) % N);
            if (!found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jkff_bank_scheduler.sv
// Round-robin scheduler sharing a bank of JK flip-flops among several requesters.
// One command per transaction: drive j/k for one cycle, settle, then ack with q.
//
//   state    | meaning
//   S_IDLE   | no owner; arbitrate when any req is high
//   S_DRIVE  | owner's j/k applied to its target bit for one edge
//   S_SETTLE | j/k released, slave stage follows master
//   S_DONE   | ack pulse with rdata/err; pointer moves past the owner
module jkff_bank_scheduler
    import jkff_bank_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IW    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [2*N_REQ-1:0]    cmd_i,
    input  logic [IW*N_REQ-1:0]   idx_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic                  ack_o,
    output logic                  rdata_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [W-1:0]          ff_j_o,
    output logic [W-1:0]          ff_k_o,
    input  logic [W-1:0]          ff_q_i
);

    localparam int PW = $clog2(N_REQ);

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_REQ-1:0]  arb_gnt;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [W-1:0]      j_q, j_d, k_q, k_d;
    logic              ack_q, ack_d, rdata_q, rdata_d, err_q, err_d, busy_q, busy_d;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (|req_i) state_d = S_DRIVE;
            S_DRIVE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        j_d     = '0;
        k_d     = '0;
        ack_d   = 1'b0;
        rdata_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);

        if (state_q == S_IDLE) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (arb_gnt[r]) begin
                    cmd_d = cmd_i[2*r +: 2];
                    idx_d = idx_i[IW*r +: IW];
                    win_d = PW'(r);
                end
            end
        end

        if (state_q == S_DONE) begin
            if (win_q == PW'(N_REQ - 1)) ptr_d = '0;
            else                         ptr_d = win_q + 1'b1;
        end

        case (state_d)
            S_DRIVE: begin
                gnt_d = arb_gnt;
                if (!idx_oob(32'(idx_d), W)) begin
                    for (int i = 0; i < W; i++) begin
                        if (idx_d == IW'(i)) begin
                            case (cmd_d)
                                CMD_RST:  k_d[i] = 1'b1;
                                CMD_SET:  j_d[i] = 1'b1;
                                CMD_TGL:  begin j_d[i] = 1'b1; k_d[i] = 1'b1; end
                                CMD_HOLD: ;
                                default:  ;
                            endcase
                        end
                    end
                end
            end
            S_SETTLE: gnt_d = gnt_q;
            S_DONE: begin
                gnt_d = gnt_q;
                ack_d = 1'b1;
                err_d = idx_oob(32'(idx_q), W);
                if (!err_d) begin
                    for (int i = 0; i < W; i++) begin
                        if (idx_q == IW'(i)) rdata_d = ff_q_i[i];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= CMD_HOLD;
            idx_q   <= '0;
            gnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ack_q   <= 1'b0;
            rdata_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign ff_j_o  = j_q;
    assign ff_k_o  = k_q;

endmodule
